sobel_frame_ctrl: RTL
=====================

// Module: sobel_frame_ctrl
// PURPOSE
//  Frame sequencer for the Sobel path. On start, reads one frame from a synchronous-read
//  frame RAM in raster order and streams the pixels into the 3x3 line buffer over a
//  valid/ready link. It then counts window-valid pulses until the frame is complete and
//  reports done or error. Clears the line buffer before every frame.
// PARAMETERS
//  DATA_WIDTH    8    pixel width
//  IMG_WIDTH     8    pixels per row, >=3
//  IMG_HEIGHT    8    rows per frame, >=3
//  ADDR_WIDTH    $clog2(IMG_WIDTH*IMG_HEIGHT)   frame RAM address width
//  DRAIN_TIMEOUT 64   max cycles in DRAIN before error
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  start        in   1           1-cycle request; accepted only in IDLE
//  abort        in   1           synchronous abort; returns to IDLE
//  busy         out  1           high from accepted start until done/err/abort
//  done         out  1           1-cycle pulse: frame completed cleanly
//  err          out  1           1-cycle pulse: drain timeout
//  lb_clear     out  1           1-cycle active-high clear to the line buffer
//  mem_rd_en    out  1           frame RAM read strobe
//  mem_addr     out  ADDR_WIDTH  frame RAM read address
//  mem_rd_data  in   DATA_WIDTH  RAM data, valid 1 cycle after mem_rd_en
//  pix_out      out  DATA_WIDTH  pixel to the line buffer
//  pix_valid    out  1           pix_out valid
//  pix_ready    in   1           line buffer accepts; transfer = pix_valid & pix_ready
//  win_valid    in   1           window-valid strobe from the line buffer
//  frame_cnt    out  16          completed (done) frames; wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, skid FIFO empty, no read pending.
//  FSM: IDLE -start-> CLEAR (lb_clear=1 for 1 cycle, addr=0) -> FETCH.
//   FETCH -> DRAIN when all N=IMG_WIDTH*IMG_HEIGHT reads are issued, the FIFO is empty,
//   and no read is pending.
//   DRAIN -> DONE once the window count reaches (IMG_WIDTH-2)*(IMG_HEIGHT-2).
//   DRAIN -> ERR if DRAIN_TIMEOUT cycles pass without completion.
//   DONE/ERR: the done/err pulse is asserted for that 1 cycle, then IDLE.
//  Window count: win_valid pulses are counted from CLEAR onward, including during FETCH.
//  busy is high in CLEAR, FETCH, DRAIN, DONE and ERR; it drops in IDLE.
//  Read path: 2-entry skid FIFO between RAM and pix_out.
//   Issue a read in FETCH when addr<N and (fifo_cnt + pending - pop) < 2.
//   pop = pix_valid & pix_ready. The address increments by 1 per issued read.
//   RAM data is pushed into the FIFO the cycle after the read.
//   pix_valid = FIFO non-empty; pix_out = FIFO head.
//   pix_out is held stable while pix_valid & !pix_ready.
//  Throughput: with pix_ready held high, 1 pixel/cycle after a 2-cycle initial latency
//   (read issue -> data -> pix_valid).
//  Ordering: pixels leave strictly in address order 0..N-1, with no drop or duplicate.
//  start while busy: ignored. start and abort in the same cycle in IDLE: abort wins.
//  abort in any non-IDLE state:
//   - FIFO flushed, pending read discarded, pix_valid=0 next cycle
//   - lb_clear pulsed 1 cycle, then IDLE
//   - no done/err pulse; frame_cnt unchanged
//  rst_n low mid-frame: immediate return to reset values; the next start begins at addr 0.
//  frame_cnt increments in DONE only.
// TESTING
//  1. IMG 4x4, ready=1, start -> lb_clear 1 cycle; addrs 0..15 on consecutive cycles;
//     pix_out=mem[i]; bench pulses win_valid 4x -> done pulse, frame_cnt=1, busy=0.
//  2. Backpressure: ready=0 for 4 cycles after pixel 5 -> pix_out stays mem[5];
//     at most 2 reads outstanding; all 16 pixels delivered in order.
//  3. Timeout: win_valid never pulsed -> err exactly DRAIN_TIMEOUT cycles after DRAIN
//     entry; done=0; frame_cnt unchanged.
//  4. start re-pulsed during FETCH -> ignored; addresses do not restart; one done only.
//  5. abort at pixel 7 -> pix_valid=0 next cycle, lb_clear pulse, IDLE;
//     a new start re-reads from addr 0.
//  6. rst_n low mid-FETCH for 1 cycle -> all outputs 0; frame_cnt=0; a clean frame
//     follows a later start.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel path: clears the line buffer, streams one frame
// from the synchronous-read frame RAM through a 2-entry skid FIFO, then waits
// for the expected number of window-valid strobes and reports done or error.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; busy low
// S_CLEAR | line-buffer clear pulse, read address reset to 0
// S_FETCH | issuing RAM reads and streaming pixels out
// S_DRAIN | all pixels delivered; waiting for the last windows
// S_DONE  | frame complete: done pulse, frame counter bumped
// S_ERR   | drain timer expired: err pulse
// S_ABORT | abort taken: FIFO flushed, line-buffer clear pulse
module sobel_frame_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int IMG_WIDTH     = 8,
    parameter int IMG_HEIGHT    = 8,
    parameter int ADDR_WIDTH    = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  lb_clear_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [DATA_WIDTH-1:0] pix_out_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    input  logic                  win_valid_i,
    output logic [15:0]           frame_cnt_o
);

    localparam int N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int WIN_N = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
    // One extra bit so the read counter can hold N itself
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int TW    = $clog2(DRAIN_TIMEOUT) + 1;

    localparam logic [CW-1:0] N_L      = CW'(N);
    localparam logic [CW-1:0] WIN_N_L  = CW'(WIN_N);
    localparam logic [TW-1:0] TMR_INIT = TW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_DONE,
        S_ERR,
        S_ABORT
    } state_e;

    state_e                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  lb_clear_q;
    logic [CW-1:0]         win_cnt_q;
    logic [CW-1:0]         rd_cnt_q;
    logic [TW-1:0]         tmr_q;
    logic [15:0]           frame_cnt_q;
    logic                  rd_pend_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            fifo_cnt_q;
    logic [1:0]            fifo_cnt_d;

    logic                  start_ok;
    logic                  abort_ok;
    logic                  count_win;
    logic                  push;
    logic                  pop;
    logic [2:0]            occ;
    logic                  rd_issue;
    logic                  fetch_done;

    // Abort wins over start in IDLE; abort is a no-op outside an active frame
    assign start_ok   = (state_q == S_IDLE) && start_i && !abort_i;
    assign abort_ok   = abort_i && (state_q != S_IDLE) && (state_q != S_ABORT);
    assign count_win  = (state_q == S_CLEAR) || (state_q == S_FETCH) || (state_q == S_DRAIN);

    assign push       = rd_pend_q;
    assign pop        = pix_valid_o && pix_ready_i;
    // Slots already claimed: buffered data plus the read in flight, less what leaves now
    assign occ        = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign rd_issue   = (state_q == S_FETCH) && !abort_i && (rd_cnt_q < N_L) && (occ < 3'd2);
    assign fetch_done = (rd_cnt_q == N_L) && (fifo_cnt_q == 2'd0) && !rd_pend_q;

    assign mem_rd_en_o = rd_issue;
    assign mem_addr_o  = rd_cnt_q[ADDR_WIDTH-1:0];
    assign pix_valid_o = (fifo_cnt_q != 2'd0);
    assign pix_out_o   = fifo_q[rd_ptr_q];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign lb_clear_o  = lb_clear_q;
    assign frame_cnt_o = frame_cnt_q;

    // FIFO occupancy after this cycle's push and pop
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Sequencer state, window count, drain timer and the registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lb_clear_q  <= 1'b0;
            win_cnt_q   <= '0;
            tmr_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            lb_clear_q <= 1'b0;
            if (count_win && win_valid_i && (win_cnt_q != WIN_N_L)) begin
                win_cnt_q <= win_cnt_q + CW'(1);
            end
            if (abort_ok) begin
                state_q    <= S_ABORT;
                lb_clear_q <= 1'b1;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_ok) begin
                            state_q    <= S_CLEAR;
                            lb_clear_q <= 1'b1;
                            busy_q     <= 1'b1;
                            win_cnt_q  <= '0;
                        end
                    end
                    S_CLEAR: state_q <= S_FETCH;
                    S_FETCH: begin
                        if (fetch_done) begin
                            state_q <= S_DRAIN;
                            tmr_q   <= TMR_INIT;
                        end
                    end
                    S_DRAIN: begin
                        // Completion takes priority over a timer expiring in the same cycle
                        if (win_cnt_q == WIN_N_L) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end else if (tmr_q == '0) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q - TW'(1);
                        end
                    end
                    S_DONE, S_ERR: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    S_ABORT: state_q <= S_IDLE;
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read address, in-flight read flag and the 2-entry skid FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q   <= '0;
            rd_pend_q  <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else if (abort_ok) begin
            // Buffered pixels and the returning read are dropped
            rd_pend_q  <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            rd_pend_q <= rd_issue;
            if (start_ok) begin
                rd_cnt_q <= '0;
            end else if (rd_issue) begin
                rd_cnt_q <= rd_cnt_q + CW'(1);
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_rd_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule
